// File: rtl/iot_stream_tx_if.sv
// Bundle of signals between the word producer / sensor side and iot_stream_tx.
// wr_en/full: a word is taken on the edge where wr_en=1 and full=0. in_en/busy: a byte is valid while in_en=1, and busy high at an edge holds off the next byte.
interface iot_stream_tx_if #(
  parameter int DEPTH = 4
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic           wr_en;
  logic [127:0]   wr_data;
  logic           full;
  logic           empty;
  logic [CW-1:0]  count;
  logic [2:0]     cfg_fn;
  logic           busy;
  logic           in_en;
  logic [7:0]     iot_in;
  logic [2:0]     fn_sel;
  logic           round_done;
  logic           dbg_state;

  modport master (
    output wr_en, wr_data, cfg_fn, busy,
    input  full, empty, count, in_en, iot_in, fn_sel, round_done, dbg_state
  );

  modport slave (
    input  wr_en, wr_data, cfg_fn, busy,
    output full, empty, count, in_en, iot_in, fn_sel, round_done, dbg_state
  );
endinterface

// File: rtl/iot_stream_tx.sv
// Buffers 128-bit words in a small FIFO and sends each one as 16 bytes, MSB first,
// grouping words into rounds of 8 with a function code held for the whole round.
module iot_stream_tx #(
  parameter int DEPTH = 4
) (
  input  logic           clk,
  input  logic           rst,
  iot_stream_tx_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic {IDLE = 1'b0, SEND = 1'b1} state_t;

  logic [127:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_next;
  logic          full_r;
  logic          empty_r;
  state_t        state;
  logic [3:0]    byte_idx;
  logic [2:0]    word_idx;
  logic          in_en_r;
  logic [7:0]    iot_in_r;
  logic [2:0]    fn_sel_r;
  logic          round_done_r;

  logic          push;
  logic          issue;
  logic          pop;
  logic [127:0]  head;
  logic [7:0]    head_byte;

  // Uses the registered empty flag, so a word written into an empty FIFO waits one cycle.
  assign push      = bus.wr_en & ~full_r;
  assign issue     = ~bus.busy & ((state == SEND) | ~empty_r);
  assign pop       = issue & (byte_idx == 4'd15);
  assign cnt_next  = cnt + CW'(push) - CW'(pop);
  assign head      = mem[rd_ptr];
  assign head_byte = head[{~byte_idx, 3'b000} +: 8];

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= bus.wr_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      cnt          <= '0;
      full_r       <= 1'b0;
      empty_r      <= 1'b1;
      state        <= IDLE;
      byte_idx     <= 4'd0;
      word_idx     <= 3'd0;
      in_en_r      <= 1'b0;
      iot_in_r     <= 8'd0;
      fn_sel_r     <= 3'd0;
      round_done_r <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      cnt          <= cnt_next;
      full_r       <= (cnt_next == CW'(DEPTH));
      empty_r      <= (cnt_next == '0);
      in_en_r      <= issue;
      round_done_r <= pop & (word_idx == 3'd7);
      if (issue) begin
        iot_in_r <= head_byte;
        byte_idx <= byte_idx + 4'd1;
        if ((byte_idx == 4'd0) && (word_idx == 3'd0)) fn_sel_r <= bus.cfg_fn;
      end
      if (pop) word_idx <= word_idx + 3'd1;
      case (state)
        IDLE:    if (issue) state <= SEND;
        SEND:    if (pop && (cnt_next == '0)) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.full       = full_r;
  assign bus.empty      = empty_r;
  assign bus.count      = cnt;
  assign bus.in_en      = in_en_r;
  assign bus.iot_in     = iot_in_r;
  assign bus.fn_sel     = fn_sel_r;
  assign bus.round_done = round_done_r;
  assign bus.dbg_state  = (state == SEND);
endmodule

// File: tb/tb_iot_stream_tx.sv
// Directed bench for iot_stream_tx: byte tables for single word and back-pressure,
// plus hand-written FIFO-full, full-round/cfg_fn and reset-mid-word sequences.
module tb_iot_stream_tx;
  localparam int DEPTH = 4;

  typedef struct {
    logic       busy;
    logic       en;
    logic [7:0] data;
    logic       empty;
  } vec_t;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_errors;
  vec_t tv[$];
  logic [127:0] exp_q[$];

  iot_stream_tx_if #(.DEPTH(DEPTH)) bus ();
  iot_stream_tx #(.DEPTH(DEPTH)) dut (.clk(clk), .rst(rst), .bus(bus));

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [127:0] word_of(input int k);
    logic [127:0] w;
    for (int j = 0; j < 16; j++) w[8*(15-j) +: 8] = 8'(k*16 + j);
    return w;
  endfunction

  task automatic check_reset(input string tag);
    chk({tag, "_in_en"}, bus.in_en, 0);
    chk({tag, "_iot_in"}, bus.iot_in, 0);
    chk({tag, "_fn_sel"}, bus.fn_sel, 0);
    chk({tag, "_round_done"}, bus.round_done, 0);
    chk({tag, "_full"}, bus.full, 0);
    chk({tag, "_empty"}, bus.empty, 1);
    chk({tag, "_count"}, bus.count, 0);
    chk({tag, "_state"}, bus.dbg_state, 0);
  endtask

  task automatic do_reset(input string tag);
    rst = 1'b1;
    bus.wr_en = 1'b0;
    bus.busy = 1'b0;
    @(posedge clk); #1;
    check_reset(tag);
    rst = 1'b0;
  endtask

  // driver: single write, returns after the accepting edge
  task automatic write_word(input logic [127:0] w);
    bus.wr_en = 1'b1;
    bus.wr_data = w;
    @(posedge clk); #1;
    bus.wr_en = 1'b0;
  endtask

  task automatic run_table(input string tag);
    foreach (tv[i]) begin
      bus.busy = tv[i].busy;
      @(posedge clk); #1;
      chk({tag, "_en"}, bus.in_en, tv[i].en);
      if (tv[i].en) chk({tag, "_byte"}, bus.iot_in, tv[i].data);
      chk({tag, "_empty"}, bus.empty, tv[i].empty);
      chk({tag, "_rd"}, bus.round_done, 0);
    end
    bus.busy = 1'b0;
  endtask

  // scoreboard: drains bytes against exp_q
  task automatic drain(input string tag, input int max_cyc, input logic [2:0] exp_fn,
                       output int nbytes, output int first);
    logic [127:0] cur;
    int j;
    nbytes = 0;
    first = -1;
    for (int c = 0; c < max_cyc; c++) begin
      @(posedge clk); #1;
      chk({tag, "_rd"}, bus.round_done, 0);
      if (bus.in_en) begin
        if (first < 0) first = c;
        if (exp_q.size() == 0) chk({tag, "_extra"}, bus.in_en, 0);
        else begin
          j = nbytes % 16;
          cur = exp_q[0];
          chk({tag, "_byte"}, bus.iot_in, cur[8*(15-j) +: 8]);
          chk({tag, "_fn"}, bus.fn_sel, exp_fn);
          if (j == 15) void'(exp_q.pop_front());
        end
        nbytes++;
      end
    end
  endtask

  initial begin
    int nb;
    int first;
    int b;
    int wr_k;
    logic started;
    logic [127:0] cur;
    logic [7:0] exp_b;
    logic [2:0] exp_fn;

    n_checks = 0;
    n_errors = 0;
    rst = 1'b1;
    bus.wr_en = 1'b0;
    bus.wr_data = '0;
    bus.cfg_fn = 3'd0;
    bus.busy = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_reset("reset");
    rst = 1'b0;

    // single word: 00,11,...,FF then idle
    write_word(128'h00112233_44556677_8899AABB_CCDDEEFF);
    chk("single_wr_empty", bus.empty, 0);
    chk("single_wr_count", bus.count, 1);
    chk("single_wr_en", bus.in_en, 0);
    tv.delete();
    for (int j = 0; j < 17; j++)
      tv.push_back('{busy: 1'b0, en: (j < 16), data: 8'(j*17), empty: (j >= 15)});
    run_table("single");

    // back-pressure: 5 stall cycles after byte 6
    write_word(128'hA0A1A2A3_A4A5A6A7_A8A9AAAB_ACADAEAF);
    chk("bp_wr_en", bus.in_en, 0);
    tv.delete();
    for (int j = 0; j < 22; j++) begin
      if (j < 7)       tv.push_back('{busy: 1'b0, en: 1'b1, data: 8'(8'hA0 + j), empty: 1'b0});
      else if (j < 12) tv.push_back('{busy: 1'b1, en: 1'b0, data: 8'h00, empty: 1'b0});
      else if (j < 21) tv.push_back('{busy: 1'b0, en: 1'b1, data: 8'(8'hA0 + j - 5), empty: (j == 20)});
      else             tv.push_back('{busy: 1'b0, en: 1'b0, data: 8'h00, empty: 1'b1});
    end
    run_table("bp");

    // FIFO full under busy; word_idx is 2 so cfg_fn must not be latched
    bus.cfg_fn = 3'd7;
    bus.busy = 1'b1;
    exp_q.delete();
    for (int i = 0; i < 5; i++) begin
      bus.wr_en = 1'b1;
      bus.wr_data = word_of(i + 1);
      if (i < 4) exp_q.push_back(word_of(i + 1));
      @(posedge clk); #1;
      chk("full_count", bus.count, (i < 4) ? i + 1 : 4);
      chk("full_flag", bus.full, (i >= 3));
      chk("full_in_en", bus.in_en, 0);
    end
    bus.wr_en = 1'b0;
    bus.busy = 1'b0;
    drain("full", 80, 3'd0, nb, first);
    chk("full_nbytes", nb, 64);
    chk("full_first", first, 0);
    chk("full_empty", bus.empty, 1);
    chk("full_leftover", exp_q.size(), 0);

    // streaming rounds: fn 3, then 1 (set late in round 0), 6 set during word 3 of round 1
    do_reset("reset2");
    exp_q.delete();
    bus.cfg_fn = 3'd3;
    b = 0;
    wr_k = 0;
    started = 1'b0;
    for (int cyc = 0; cyc < 400 && b < 298; cyc++) begin
      bus.wr_en = !bus.full;
      bus.wr_data = word_of(wr_k);
      @(posedge clk); #1;
      if (bus.wr_en) begin
        exp_q.push_back(word_of(wr_k));
        wr_k++;
      end
      if (bus.in_en) started = 1'b1;
      if (started) chk("stream_en", bus.in_en, 1);
      chk("stream_rd", bus.round_done, bus.in_en && ((b % 128) == 127));
      if (bus.in_en) begin
        cur = exp_q[0];
        exp_b = cur[8*(15-(b%16)) +: 8];
        exp_fn = (b < 128) ? 3'd3 : (b < 256) ? 3'd1 : 3'd6;
        chk("stream_byte", bus.iot_in, exp_b);
        chk("stream_fn", bus.fn_sel, exp_fn);
        if ((b % 16) == 15) void'(exp_q.pop_front());
        b++;
      end
      if (b == 112) bus.cfg_fn = 3'd1;
      if (b == 181) bus.cfg_fn = 3'd6;
    end
    chk("stream_reached", b, 298);

    // reset during byte 9 of word 2 of round 2
    bus.wr_en = 1'b0;
    rst = 1'b1;
    #1;
    check_reset("midreset");
    @(posedge clk); #1;
    rst = 1'b0;
    exp_q.delete();
    bus.cfg_fn = 3'd5;
    exp_q.push_back(word_of(50));
    write_word(word_of(50));
    chk("post_wr_en", bus.in_en, 0);
    drain("post", 20, 3'd5, nb, first);
    chk("post_nbytes", nb, 16);
    chk("post_first", first, 0);
    chk("post_empty", bus.empty, 1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule

// File: doc/iot_stream_tx.md
# iot_stream_tx

Transmit-side source for the IoT data-filtering interface. It buffers 128-bit sensor words in a small FIFO and serializes each word into 16 byte transfers on `in_en`/`iot_in`, most significant byte first. It groups words into rounds of 8 and presents a round-stable `fn_sel`. It sits in front of the filter block (or the bench model of the sensor array) and honours that block's `busy` back-pressure.

## Interface
- `DEPTH`, default 4: FIFO depth in 128-bit words; power of two, ≥2.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `wr_en` in 1: write request; accepted when `wr_en & ~full`.
- `wr_data` in 128: word to enqueue.
- `full` out 1: FIFO holds `DEPTH` words.
- `empty` out 1: FIFO holds 0 words.
- `count` out log2(DEPTH)+1: words currently stored, including the word being sent.
- `cfg_fn` in 3: requested function code; sampled only at round start.
- `busy` in 1: downstream stall; while high, no byte is issued.
- `in_en` out 1: byte strobe, registered.
- `iot_in` out 8: byte data, registered; valid only when `in_en`=1.
- `fn_sel` out 3: function code for the current round, registered.
- `round_done` out 1: one-cycle pulse coincident with the last byte of the 8th word.

## Operation
- **FIFO**
  - Circular buffer with read and write pointers (log2(DEPTH) bits each) and a `count` register.
  - A write stores `wr_data` at the write pointer and increments it.
  - A pop occurs when byte 15 of the head word is issued; the read pointer increments (wraps modulo `DEPTH`).
  - Write and pop in the same cycle: `count` is unchanged.
  - Write while `full`: dropped, with no state change, even if a pop occurs in the same cycle.
  - Write while `empty`: the word becomes sendable the following cycle, never in the same cycle.
- **Serializer FSM**, 2 states, plus `byte_idx` (4 bits) and `word_idx` (3 bits):
  - **IDLE**:
    - `in_en`<=0.
    - If `~empty & ~busy`, go to SEND and issue byte 0 on this edge.
  - **SEND**, each edge:
    - If `busy`=1: `in_en`<=0; `byte_idx`, `word_idx` and state are held.
    - Else: `in_en`<=1, `iot_in` <= head[127-8*`byte_idx` -: 8], `byte_idx`++.
  - **After byte 15** is issued:
    - Pop, `byte_idx`<=0, `word_idx`++ (wraps 7→0).
    - Stay in SEND if the FIFO will still be non-empty after the pop; otherwise go to IDLE.
    - Back-to-back words have no gap cycle.
- **Round**
  - When byte 0 is issued with `word_idx`=0, `fn_sel`<=`cfg_fn`. `fn_sel` is otherwise held.
  - `round_done` is 1 in the same cycle `in_en` carries byte 15 of word 7, and 0 otherwise.
- A partial round is never padded. The next word simply continues at the current `word_idx`.

## Timing
- **Reset values:**
  - `in_en`=0, `iot_in`=0, `fn_sel`=0, `round_done`=0.
  - `full`=0, `empty`=1, `count`=0.
  - State IDLE, pointers 0, `byte_idx`=0, `word_idx`=0.
- **Reset mid-word:** the partially sent word and all buffered words are discarded, and the round counter restarts at word 0.
- **Latency:** a write at edge N (FIFO empty, `busy`=0) gives byte 0 with `in_en`=1 after edge N+1. Byte 15 follows after edge N+16.
- **Throughput:** 1 byte per cycle when `busy`=0. A word takes 16 cycles, and a round takes 128 cycles.
- **`busy` timing:** `busy` is sampled at the edge, so `busy` high at edge K suppresses the byte that would have appeared after edge K. A byte already on `iot_in` is not retracted.
- **Flags:** `full`, `empty` and `count` are registered and reflect the state after the edge.
- **`cfg_fn` changes:** changes mid-round have no effect until the next round start.

## Test plan
- **Single word:**
  - Stimulus: reset, then write 0x00112233_44556677_8899AABB_CCDDEEFF with `busy`=0.
  - Required: 16 consecutive `in_en` cycles carrying 00,11,…,FF; then `in_en`=0 and `empty`=1.
- **Full round:**
  - Stimulus: `cfg_fn`=3; stream 8 words, keeping the FIFO non-empty.
  - Required: 128 contiguous `in_en` cycles, `fn_sel`=3 throughout, one `round_done` pulse on the 128th byte.
- **Back-pressure:**
  - Stimulus: assert `busy` for 5 cycles after byte 6.
  - Required: `in_en`=0 for exactly 5 cycles; transfer resumes with byte 7; no byte is lost or repeated.
- **FIFO full:**
  - Stimulus: write 5 words with `DEPTH`=4 while `busy`=1.
  - Required: `full`=1 and `count`=4; the 5th write is dropped; only 4 words are transmitted after `busy` falls.
- **Mid-round `cfg_fn` change:**
  - Stimulus: change `cfg_fn` 1→6 during word 3.
  - Required: `fn_sel` stays 1 until byte 0 of the next round, then becomes 6.
- **Reset mid-word:**
  - Stimulus: assert `rst` during byte 9 of word 2.
  - Required: all outputs are at reset values. A new write then restarts at byte 0, word 0, and `fn_sel` is re-latched.
